// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage 16-bit pipeline.
// Ports: hazard/redirect/memory/halt status in; per-stage enables,
// flush/bubble controls, halted, mem_err and perf counters out.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT  = 64,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  id_rs,
    input  logic        id_rs_valid,
    input  logic [2:0]  id_rt,
    input  logic        id_rt_valid,
    input  logic        ex_memRead,
    input  logic [2:0]  ex_writereg,
    input  logic        ex_redirect,
    input  logic        mem_req,
    input  logic        mem_done,
    input  logic        halt_id,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_flush,
    output logic        idex_en,
    output logic        idex_flush,
    output logic        exmem_en,
    output logic        memwb_bubble,
    output logic        halted,
    output logic        mem_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t        state;
    logic [TW-1:0] toCnt;
    logic [DW-1:0] drainCnt;

    logic memStall;
    logic loadUse;
    logic toHit;
    logic haltTake;
    logic redirTake;

    assign memStall = mem_req & ~mem_done;
    assign loadUse  = ex_memRead &
                      ((id_rs_valid & (id_rs == ex_writereg)) |
                       (id_rt_valid & (id_rt == ex_writereg)));

    // Fires on the cycle the wait reaches MEM_TIMEOUT consecutive cycles.
    assign toHit = memStall & (toCnt == TW'(MEM_TIMEOUT - 1));

    assign redirTake = (state == RUN) & ~memStall & ex_redirect;
    assign haltTake  = (state == RUN) & ~memStall & ~ex_redirect &
                       ~loadUse & halt_id;

    always_comb begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;
        idex_en      = 1'b0;
        idex_flush   = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b0;
        unique case (state)
            RUN: begin
                if (memStall) begin
                    memwb_bubble = 1'b1;
                end else if (ex_redirect) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                end else if (loadUse) begin
                    idex_en    = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                end else if (halt_id) begin
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                end else begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    idex_en  = 1'b1;
                    exmem_en = 1'b1;
                end
            end
            DRAIN: begin
                // Redirects are ignored: nothing older than HALT is in EX.
                if (memStall) begin
                    memwb_bubble = 1'b1;
                end else begin
                    idex_en    = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                end
            end
            HALTED: begin
                idex_flush   = 1'b1;
                memwb_bubble = 1'b1;
            end
            default: begin
                idex_flush   = 1'b1;
                memwb_bubble = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            toCnt     <= '0;
            drainCnt  <= '0;
            halted    <= 1'b0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!memStall) begin
                toCnt <= '0;
            end else if (toCnt != TW'(MEM_TIMEOUT)) begin
                toCnt <= toCnt + 1'b1;
            end

            if (!pc_en && state != HALTED && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (redirTake && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end

            if (toHit) begin
                mem_err <= 1'b1;
                state   <= HALTED;
                halted  <= 1'b1;
            end else begin
                unique case (state)
                    RUN: begin
                        if (haltTake) begin
                            state    <= DRAIN;
                            drainCnt <= DW'(DRAIN_CYCLES);
                        end
                    end
                    DRAIN: begin
                        if (!memStall) begin
                            drainCnt <= drainCnt - 1'b1;
                            if (drainCnt == DW'(1)) begin
                                state  <= HALTED;
                                halted <= 1'b1;
                            end
                        end
                    end
                    HALTED: begin
                        halted <= 1'b1;
                    end
                    default: begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage 16-bit pipeline.
- Drives the enable and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sources of control: load-use hazards, EX-stage redirects, multi-cycle data-memory waits, and HALT drain.
- Also keeps saturating stall and flush performance counters and a memory-timeout error flag.

Parameters:
- MEM_TIMEOUT, 64: maximum consecutive cycles the pipeline waits on mem_done before mem_err is raised.
- DRAIN_CYCLES, 3: cycles needed for HALT to leave ID/EX and retire through WB.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low
- id_rs  input  3  ID-stage source register 1
- id_rs_valid  input  1  id_rs is actually read
- id_rt  input  3  ID-stage source register 2
- id_rt_valid  input  1  id_rt is actually read
- ex_memRead  input  1  instruction in ID/EX is a load
- ex_writereg  input  3  destination register of the ID/EX instruction
- ex_redirect  input  1  branch taken or jump/jumpReg resolved in EX
- mem_req  input  1  EX/MEM instruction accesses data memory
- mem_done  input  1  data memory completes this cycle
- halt_id  input  1  HALT decoded in ID
- pc_en  output  1  PC register load enable
- ifid_en  output  1  IF/ID load enable
- ifid_flush  output  1  IF/ID loads a NOP
- idex_en  output  1  ID/EX load enable
- idex_flush  output  1  ID/EX loads a bubble (all controls 0)
- exmem_en  output  1  EX/MEM load enable
- memwb_bubble  output  1  MEM/WB loads a bubble
- halted  output  1  pipeline is stopped after HALT
- mem_err  output  1  sticky memory-timeout flag
- stall_cnt  output  16  saturating count of cycles with pc_en=0 while not halted
- flush_cnt  output  16  saturating count of accepted redirects

Behaviour:
- States: RUN, DRAIN, HALTED. Register state, drain counter, timeout counter, perf counters and mem_err. All enable/flush outputs are combinational from state and inputs; there is no added latency.
- Reset (rst=0, async): state=RUN, both perf counters=0, halted=0, mem_err=0, timeout counter=0, drain counter=0.
- memstall = mem_req & ~mem_done.
- loaduse = ex_memRead & ((id_rs_valid & id_rs==ex_writereg) | (id_rt_valid & id_rt==ex_writereg)).
- Priority in RUN, highest first:
  1. memstall: pc_en = ifid_en = idex_en = exmem_en = 0; memwb_bubble=1; no flushes.
  2. ex_redirect: all enables 1; ifid_flush=1; idex_flush=1; flush_cnt++.
  3. loaduse: pc_en=0, ifid_en=0; idex_flush=1; exmem_en=1.
  4. halt_id: pc_en=0, ifid_en=0; ID/EX captures HALT normally; next state DRAIN with drain counter=DRAIN_CYCLES.
  5. otherwise: all enables 1, all flush/bubble 0.
- ex_redirect together with halt_id: redirect wins and HALT is flushed; remain in RUN.
- DRAIN:
  - pc_en=0, ifid_en=0; idex_flush=1 every non-memstall cycle.
  - memstall still freezes the pipeline and the drain counter holds.
  - Otherwise the counter decrements; at 0 the next state is HALTED.
  - ex_redirect is ignored: no older instruction can be in EX.
- HALTED:
  - All enables 0, idex_flush=1, memwb_bubble=1, halted=1.
  - Stays until reset; stall_cnt does not count here.
- Timeout counter:
  - Increments each cycle memstall=1 and clears otherwise.
  - When it reaches MEM_TIMEOUT: mem_err=1 (sticky) and next state HALTED regardless of the current state.
- stall_cnt increments when pc_en=0 and state≠HALTED. Both counters saturate at 0xFFFF with no wrap.
- Reset asserted mid-stall or mid-drain returns to RUN immediately with all registers cleared.

Test Plan:
- Load-use: ex_memRead=1, ex_writereg=3, id_rs=3, id_rs_valid=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; stall_cnt=1.
- Same as load-use but id_rs_valid=0 and id_rt≠3 -> no stall; all enables 1; stall_cnt=0.
- Redirect with simultaneous loaduse and halt_id -> ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt=1; state stays RUN.
- mem_req=1, mem_done=0 for 5 cycles, then mem_done=1 -> exmem_en=0 and memwb_bubble=1 for 5 cycles, released on cycle 6; stall_cnt=5; mem_err=0.
- halt_id pulse with a memstall of 2 cycles during DRAIN -> halted rises 3+2 cycles after the pulse; then all enables 0 until rst.
- MEM_TIMEOUT=4, mem_done held 0 -> mem_err=1 and halted=1 on the 5th cycle. Then assert rst=0 mid-HALTED -> outputs return to reset values asynchronously.
